// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, keeps up to FIFO_DEPTH fetches (outstanding or returned) with their
// PCs, and hands {PC, instruction} to decode over valid/ready. A redirect
// flushes everything buffered and arranges for stale responses to be dropped.
module inst_fetch_unit #(
    parameter int                    Inst_Data_width = 32,
    parameter int                    Addr_width      = 32,
    parameter logic [Addr_width-1:0] RESET_PC        = '0,
    parameter int                    FIFO_DEPTH      = 2
) (
    input  logic                       i_CLK,
    input  logic                       i_RST_n,
    output logic                       o_IMEM_REQ,
    output logic [Addr_width-1:0]      o_IMEM_ADDR,
    input  logic                       i_IMEM_GNT,
    input  logic                       i_IMEM_RVALID,
    input  logic [Inst_Data_width-1:0] i_IMEM_RDATA,
    input  logic                       i_REDIRECT,
    input  logic [Addr_width-1:0]      i_REDIRECT_PC,
    output logic                       o_INST_VALID,
    output logic [Inst_Data_width-1:0] o_INST_D,
    output logic [Addr_width-1:0]      o_INST_PC,
    input  logic                       i_INST_READY
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Filled entries always form a contiguous run starting at the head,
    // because responses come back in grant order. So a fill count replaces
    // per-entry filled bits, and the oldest unfilled slot is head + nfill.
    logic [Addr_width-1:0]      pc_reg;
    logic [CW-1:0]              count_reg;
    logic [CW-1:0]              nfill_reg;
    logic [CW-1:0]              drop_reg;
    logic [PW-1:0]              head_reg;
    logic [PW-1:0]              tail_reg;
    logic [Addr_width-1:0]      pc_mem   [FIFO_DEPTH];
    logic [Inst_Data_width-1:0] data_mem [FIFO_DEPTH];

    logic                  grant;
    logic                  pop;
    logic                  fill;
    logic                  drop_hit;
    logic [CW-1:0]         unfilled;
    logic [CW-1:0]         grant_c;
    logic [CW-1:0]         pop_c;
    logic [CW-1:0]         fill_c;
    logic [CW-1:0]         hit_c;
    logic [PW-1:0]         fill_idx;
    logic [Addr_width-1:0] redirect_target;

    // Request is gated by reset so it is low while held in reset even though
    // the registered count is already zero.
    assign o_IMEM_REQ      = i_RST_n & (count_reg < DEPTH_C);
    assign o_IMEM_ADDR     = pc_reg;
    assign grant           = o_IMEM_REQ & i_IMEM_GNT;
    assign unfilled        = count_reg - nfill_reg;
    assign pop             = (nfill_reg != '0) & i_INST_READY;
    assign drop_hit        = i_IMEM_RVALID & (drop_reg != '0);
    assign fill            = i_IMEM_RVALID & (drop_reg == '0) & (unfilled != '0);
    assign fill_idx        = head_reg + PW'(nfill_reg);
    assign grant_c         = CW'(grant);
    assign pop_c           = CW'(pop);
    assign fill_c          = CW'(fill);
    assign hit_c           = CW'(drop_hit);
    assign redirect_target = i_REDIRECT_PC & ~Addr_width'(3);

    assign o_INST_VALID = (nfill_reg != '0);
    assign o_INST_D     = data_mem[head_reg];
    assign o_INST_PC    = pc_mem[head_reg];

    // PC, occupancy pointers and stale-response counter.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            pc_reg    <= RESET_PC;
            count_reg <= '0;
            nfill_reg <= '0;
            drop_reg  <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else if (i_REDIRECT) begin
            // Everything still in flight becomes stale: unfilled entries,
            // plus a grant to the old PC this cycle, minus a response that
            // lands in an unfilled entry right now (it is flushed anyway).
            pc_reg    <= redirect_target;
            count_reg <= '0;
            nfill_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            drop_reg  <= drop_reg - hit_c + unfilled + grant_c - fill_c;
        end else begin
            if (grant) begin
                pc_reg <= pc_reg + Addr_width'(4);
            end
            count_reg <= count_reg + grant_c - pop_c;
            nfill_reg <= nfill_reg + fill_c - pop_c;
            head_reg  <= head_reg + PW'(pop);
            tail_reg  <= tail_reg + PW'(grant);
            drop_reg  <= drop_reg - hit_c;
        end
    end

    // Entry storage: PC captured on grant, instruction captured on response.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (!i_REDIRECT) begin
            if (grant) begin
                pc_mem[tail_reg] <= pc_reg;
            end
            if (fill) begin
                data_mem[fill_idx] <= i_IMEM_RDATA;
            end
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding (live or stale) is a memory-side
    // protocol error; the logic ignores it, simulation flags it.
    assert property (@(posedge i_CLK) disable iff (!i_RST_n)
        i_IMEM_RVALID |-> ((drop_reg != '0) || (unfilled != '0)));
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: behavioural IMEM (in-order responses, optional
// gaps), a scoreboard of expected {PC, instruction} deliveries, and a model
// of request/address/valid behaviour checked every cycle.
module tb_inst_fetch_unit;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          gnt = 1'b0;
    logic          rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          inst_valid;
    logic [DW-1:0] inst_d;
    logic [AW-1:0] inst_pc;
    logic          ready = 1'b0;
    logic          resp_en = 1'b1;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .Inst_Data_width(DW),
        .Addr_width     (AW),
        .RESET_PC       (RPC),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .i_CLK        (clk),
        .i_RST_n      (rst_n),
        .o_IMEM_REQ   (imem_req),
        .o_IMEM_ADDR  (imem_addr),
        .i_IMEM_GNT   (gnt),
        .i_IMEM_RVALID(rvalid),
        .i_IMEM_RDATA (rdata),
        .i_REDIRECT   (redirect),
        .i_REDIRECT_PC(redirect_pc),
        .o_INST_VALID (inst_valid),
        .o_INST_D     (inst_d),
        .o_INST_PC    (inst_pc),
        .i_INST_READY (ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] exp_q[$];   // live allocated entries (PCs), oldest first
    logic [31:0] pend_q[$];  // addresses granted and not yet answered by IMEM
    int          n_ret;      // live entries at the head that have their data
    int          n_stale;    // leading pend_q entries whose responses are stale
    logic [31:0] exp_pc;
    bit          want_first;
    logic [31:0] first_pc;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // One clock cycle: check outputs at the falling edge, advance the model
    // for the coming rising edge, then drive the IMEM response for next cycle.
    task automatic cycle();
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] e_pc;
        logic [31:0] r_addr;
        @(negedge clk);
        exp_req   = (exp_q.size() < DEPTH);
        exp_valid = (n_ret > 0);
        check("req", imem_req, exp_req);
        if (exp_req) check("addr", imem_addr, exp_pc);
        check("valid", inst_valid, exp_valid);
        if (exp_valid && ready) begin
            e_pc = exp_q.pop_front();
            n_ret--;
            check("inst_pc", inst_pc, e_pc);
            check("inst_d", inst_d, imem_word(e_pc));
            $display("deliver pc=0x%08h inst=0x%08h", inst_pc, inst_d);
            if (want_first) begin
                first_pc   = inst_pc;
                want_first = 1'b0;
            end
        end
        if (rvalid) begin
            r_addr = pend_q.pop_front();
            if (n_stale > 0) n_stale--;
            else             n_ret++;
        end
        if (exp_req && gnt) begin
            pend_q.push_back(exp_pc);
            if (!redirect) exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect) begin
            exp_q.delete();
            n_ret      = 0;
            n_stale    = pend_q.size();
            exp_pc     = redirect_pc & ~32'h3;
            want_first = 1'b1;
            first_pc   = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        if (resp_en && pend_q.size() > 0) begin
            rvalid = 1'b1;
            rdata  = imem_word(pend_q[0]);
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
    endtask

    // Asserts reset between clock edges, checks outputs clear at once,
    // resets the IMEM model, then releases reset between edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_d", inst_d, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        gnt = 1'b0; ready = 1'b0; redirect = 1'b0;
        rvalid = 1'b0; rdata = '0; resp_en = 1'b1;
        exp_q.delete();
        pend_q.delete();
        n_ret = 0; n_stale = 0;
        exp_pc = RPC;
        want_first = 1'b1;
        first_pc = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        logic [31:0] tgt;

        do_reset();

        // Streaming with immediate responses and decode always ready
        gnt = 1'b1; ready = 1'b1;
        repeat (12) cycle();
        check("t1_first_pc", first_pc, RPC);

        // Decode stalls: FIFO fills, requests stop, head held
        do_reset();
        gnt = 1'b1; ready = 1'b0;
        repeat (4) cycle();
        check("t2_req_low", imem_req, 1'b0);
        check("t2_addr_held", imem_addr, 32'h108);
        check("t2_valid", inst_valid, 1'b1);
        check("t2_head_pc", inst_pc, 32'h100);
        ready = 1'b1;
        repeat (10) cycle();
        check("t2_first_pc", first_pc, 32'h100);

        // Grant withheld: address must not move
        gnt = 1'b0;
        repeat (5) cycle();
        check("t3_addr_stable", imem_addr, exp_pc);
        gnt = 1'b1;
        repeat (6) cycle();

        // Redirect with two granted, unreturned fetches
        do_reset();
        gnt = 1'b1; ready = 1'b1; resp_en = 1'b0;
        repeat (2) cycle();
        redirect = 1'b1; redirect_pc = 32'h2002; resp_en = 1'b1;
        cycle();
        check("t4_addr", imem_addr, 32'h2000);
        repeat (12) cycle();
        check("t4_first_pc", first_pc, 32'h2000);

        // Redirect at every phase of the stream (pop/grant/response overlaps)
        for (int off = 1; off <= 6; off++) begin
            do_reset();
            gnt = 1'b1; ready = 1'b1;
            repeat (off) cycle();
            tgt = 32'h3000 + 32'(off) * 32'h40 + 32'(off % 4);
            redirect = 1'b1; redirect_pc = tgt;
            cycle();
            repeat (12) cycle();
            check("t5_first_pc", first_pc, tgt & ~32'h3);
        end

        // PC wraps at the top of the address space
        do_reset();
        gnt = 1'b1; ready = 1'b1;
        cycle();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        repeat (14) cycle();
        check("t7_first_pc", first_pc, 32'hFFFF_FFFC);

        // Reset asserted mid-stream while an instruction is presented
        do_reset();
        gnt = 1'b1; ready = 1'b0;
        guard = 0;
        while (!inst_valid && guard < 20) begin
            cycle();
            guard++;
        end
        check("t6_valid_before_rst", inst_valid, 1'b1);
        do_reset();
        gnt = 1'b1; ready = 1'b1;
        repeat (10) cycle();
        check("t6_first_pc", first_pc, RPC);

        // Random handshakes, response gaps and occasional redirects
        for (int i = 0; i < 300; i++) begin
            gnt     = ($urandom_range(0, 3) != 0);
            ready   = ($urandom_range(0, 3) != 0);
            resp_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0 && pend_q.size() <= 1) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
            end
            cycle();
        end
        gnt = 1'b0; ready = 1'b1; resp_en = 1'b1;
        repeat (8) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
